vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_timing_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and timing helpers for the VGA timing generator.
// Defaults describe 640x480 at 60 Hz.
package vga_timing_pkg;

  localparam int unsigned POS_W     = 10;
  localparam int unsigned MAX_TOTAL = 1024;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Sync window on one axis: asserted for start <= pos < stop.
  typedef struct packed {
    int unsigned start;
    int unsigned stop;
  } sync_window_t;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic sync_window_t sync_window(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync);
    sync_window_t w;
    w.start = active + fp;
    w.stop  = active + fp + sync;
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active/sync
// decode computed from the next position so flags never lag the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter logic        POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [POS_W-1:0] pos,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int unsigned  TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam sync_window_t SW    = sync_window(ACTIVE, FP, SYNC);

  localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] ACT_END    = POS_W'(ACTIVE);
  localparam logic [POS_W-1:0] SYNC_START = POS_W'(SW.start);
  localparam logic [POS_W-1:0] SYNC_STOP  = POS_W'(SW.stop);

  if (TOTAL > MAX_TOTAL || TOTAL < 2) begin : g_bad_total
    $error("vga_axis_counter: axis total %0d outside 2..%0d", TOTAL, MAX_TOTAL);
  end

  logic [POS_W-1:0] pos_next;

  always_comb begin
    wrap     = (pos == LAST);
    pos_next = wrap ? '0 : pos + POS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= LAST;
      active <= 1'b0;
      sync   <= ~POL;
    end else if (step) begin
      pos    <= pos_next;
      active <= (pos_next < ACT_END);
      sync   <= (pos_next >= SYNC_START && pos_next < SYNC_STOP) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical axis counters plus line and
// frame pulses and a wrapping frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  logic h_active, h_wrap;
  logic v_active, v_wrap;
  logic v_step;

  assign v_step = clk_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (clk_en),
    .pos    (hpos),
    .active (h_active),
    .sync   (hsync),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (v_step),
    .pos    (vpos),
    .active (v_active),
    .sync   (vsync),
    .wrap   (v_wrap)
  );

  // Both flags are flops updated in the same cycle as the counters.
  assign de = h_active & v_active;

  // The strobe that wraps hpos is the one that lands on column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= v_step;
      frame_start <= v_step & v_wrap;
      if (v_step && v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
